aesl_axis_block_detector: RTL and testbench

AESL_AXIS_BLOCK_DETECTOR -- requirements
Module: aesl_axis_block_detector

---
 rtl/aesl_deadlock_pkg.sv | 19 +
 rtl/aesl_axis_block_chan.sv | 90 +++++++++
 rtl/aesl_axis_block_detector.sv | 111 +++++++++++
 tb/tb_aesl_axis_block_detector.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_pkg.sv
// Shared types for the AXI-stream deadlock detection blocks: per-channel
// FSM state encoding, default counter width and the stall predicate.
package aesl_deadlock_pkg;

  localparam int AESL_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } blk_state_e;

  // An input stream stalls when the kernel is ready but nothing arrives;
  // an output stream stalls when the kernel offers data nobody takes.
  function automatic logic stall_of(input logic dir, input logic tvalid, input logic tready);
    return dir ? (tready & ~tvalid) : (tvalid & ~tready);
  endfunction

endpackage

// File: rtl/aesl_axis_block_chan.sv
// One watched AXI-stream channel: counts consecutive stall cycles and raises
// a registered blocked flag once the run reaches STALL_THRESH.
module aesl_axis_block_chan
  import aesl_deadlock_pkg::*;
#(
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = AESL_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tvalid_i,
  input  logic             tready_i,
  input  logic             dir_i,
  input  logic             inst_idle_i,
  output logic             blocked_o,
  output logic             blk_nxt_o,
  output logic             block_evt_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] THR    = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(STALL_THRESH - 1);

  blk_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             blocked_q;
  logic             stall;
  logic             xfer;

  assign stall = stall_of(dir_i, tvalid_i, tready_i);
  assign xfer  = tvalid_i & tready_i;

  // Next value of the flag, exported so the top can register its OR and
  // spot new blocks in the same edge the flag itself is registered.
  assign blk_nxt_o   = ~inst_idle_i & stall &
                       (((state_q == ST_COUNT) && (cnt_q >= THR_M1)) || (state_q == ST_BLOCKED));
  assign block_evt_o = blk_nxt_o & (state_q != ST_BLOCKED);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      blocked_q <= 1'b0;
    end else begin
      blocked_q <= blk_nxt_o;
      if (inst_idle_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (stall) begin
              state_q <= ST_COUNT;
              cnt_q   <= CNT_W'(1);
            end
          end
          ST_COUNT: begin
            if (!stall) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else if (cnt_q >= THR_M1) begin
              state_q <= ST_BLOCKED;
              cnt_q   <= THR;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_BLOCKED: begin
            if (xfer || !stall) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= THR;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign blocked_o = blocked_q;
  assign state_o   = state_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/aesl_axis_block_detector.sv
// Watches NUM_CH AXI-stream channels and reports which are blocked.
// Optional first-block trace capture is enabled by AESL_BLOCK_TRACE_EN.
module aesl_axis_block_detector
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = AESL_CNT_W_DEF,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic [NUM_CH-1:0] ch_dir,
  input  logic              inst_idle,
  input  logic              trace_clr,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              block_any,
  output logic [CH_W-1:0]   first_block_ch,
  output logic [31:0]       first_block_cycle,
  output logic              trace_valid
);

  logic [NUM_CH-1:0]       blk_nxt;
  logic [NUM_CH-1:0]       blk_evt;
  logic [2*NUM_CH-1:0]     chan_state;
  logic [CNT_W*NUM_CH-1:0] chan_cnt;
  logic                    block_any_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    aesl_axis_block_chan #(
      .STALL_THRESH(STALL_THRESH),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i      (clock),
      .rst_ni     (reset_n),
      .tvalid_i   (ch_tvalid[g]),
      .tready_i   (ch_tready[g]),
      .dir_i      (ch_dir[g]),
      .inst_idle_i(inst_idle),
      .blocked_o  (axis_block_sigs[g]),
      .blk_nxt_o  (blk_nxt[g]),
      .block_evt_o(blk_evt[g]),
      .state_o    (chan_state[2*g +: 2]),
      .cnt_o      (chan_cnt[CNT_W*g +: CNT_W])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) block_any_q <= 1'b0;
    else          block_any_q <= |blk_nxt;
  end
  assign block_any = block_any_q;

  logic unused_dbg;
  assign unused_dbg = ^{chan_state, chan_cnt};

`ifdef AESL_BLOCK_TRACE_EN
  logic [31:0]     cycle_q;
  logic [31:0]     cycle_d;
  logic [CH_W-1:0] evt_idx;
  logic            evt_any;
  logic [CH_W-1:0] first_ch_q;
  logic [31:0]     first_cyc_q;
  logic            trace_valid_q;

  // Stamp is the cycle in which the new flag first shows on the outputs.
  assign cycle_d = cycle_q + 32'd1;
  assign evt_any = |blk_evt;

  // Downward scan so the lowest blocking index is the one left standing.
  always_comb begin
    evt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (blk_evt[i]) evt_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q       <= '0;
      first_ch_q    <= '0;
      first_cyc_q   <= '0;
      trace_valid_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      if (evt_any && (!trace_valid_q || trace_clr)) begin
        first_ch_q    <= evt_idx;
        first_cyc_q   <= cycle_d;
        trace_valid_q <= 1'b1;
      end else if (trace_clr) begin
        first_ch_q    <= '0;
        first_cyc_q   <= '0;
        trace_valid_q <= 1'b0;
      end
    end
  end

  assign first_block_ch    = first_ch_q;
  assign first_block_cycle = first_cyc_q;
  assign trace_valid       = trace_valid_q;
`else
  logic unused_trace;
  assign unused_trace      = ^{trace_clr, blk_evt};
  assign first_block_ch    = '0;
  assign first_block_cycle = '0;
  assign trace_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_aesl_axis_block_detector.sv
// Randomized scoreboard bench for aesl_axis_block_detector (STALL_THRESH=4);
// the reference model tracks per-channel consecutive-stall run lengths.
module tb_aesl_axis_block_detector;

  localparam int N  = 3;
  localparam int TH = 4;
  localparam int W  = 39;
`ifdef AESL_BLOCK_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] ch_tvalid = '0;
  logic [N-1:0] ch_tready = '0;
  logic [N-1:0] ch_dir = 3'b101;
  logic         inst_idle = 1'b0;
  logic         trace_clr = 1'b0;
  logic [N-1:0] axis_block_sigs;
  logic         block_any;
  logic [1:0]   first_block_ch;
  logic [31:0]  first_block_cycle;
  logic         trace_valid;

  aesl_axis_block_detector #(
    .NUM_CH      (N),
    .STALL_THRESH(TH),
    .CNT_W       (8)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .ch_tvalid        (ch_tvalid),
    .ch_tready        (ch_tready),
    .ch_dir           (ch_dir),
    .inst_idle        (inst_idle),
    .trace_clr        (trace_clr),
    .axis_block_sigs  (axis_block_sigs),
    .block_any        (block_any),
    .first_block_ch   (first_block_ch),
    .first_block_cycle(first_block_cycle),
    .trace_valid      (trace_valid)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: run length of consecutive stall cycles per channel
  int          run_m[N];
  logic [N-1:0] flag_m;
  logic        tv_m;
  logic [1:0]  ch_m;
  logic [31:0] cyc_m;
  logic [31:0] stamp_m;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) run_m[i] = 0;
    flag_m  = '0;
    tv_m    = 1'b0;
    ch_m    = '0;
    cyc_m   = '0;
    stamp_m = '0;
  endfunction

  function automatic void model_step(input logic [N-1:0] v, input logic [N-1:0] r,
                                     input logic idl, input logic clr);
    logic [N-1:0] nf;
    logic         st;
    int           lowest;
    lowest = -1;
    for (int i = 0; i < N; i++) begin
      st = ch_dir[i] ? (r[i] && !v[i]) : (v[i] && !r[i]);
      if (idl || !st)    run_m[i] = 0;
      else if (run_m[i] < TH) run_m[i] = run_m[i] + 1;
      nf[i] = (run_m[i] >= TH);
      if (nf[i] && !flag_m[i] && lowest < 0) lowest = i;
    end
    cyc_m = cyc_m + 32'd1;
    if (lowest >= 0 && (!tv_m || clr)) begin
      tv_m    = 1'b1;
      ch_m    = 2'(lowest);
      stamp_m = cyc_m;
    end else if (clr) begin
      tv_m    = 1'b0;
      ch_m    = '0;
      stamp_m = '0;
    end
    flag_m = nf;
    exp_q.push_back({TR ? tv_m : 1'b0, TR ? ch_m : 2'b00, TR ? stamp_m : 32'd0, |nf, nf});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus, expected response queued for the monitor
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r,
                       input logic idl, input logic clr);
    @(negedge clock);
    ch_tvalid = v;
    ch_tready = r;
    inst_idle = idl;
    trace_clr = clr;
    model_step(v, r, idl, clr);
  endtask

  task automatic drive_n(input int n, input logic [N-1:0] v, input logic [N-1:0] r,
                         input logic idl);
    for (int k = 0; k < n; k++) drive(v, r, idl, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sigs"}, 64'(axis_block_sigs), 64'd0);
    check({tag, "_any"}, 64'(block_any), 64'd0);
    check({tag, "_tvalid"}, 64'(trace_valid), 64'd0);
    check({tag, "_ch"}, 64'(first_block_ch), 64'd0);
    check({tag, "_cyc"}, 64'(first_block_cycle), 64'd0);
  endtask

  // asynchronous reset mid-cycle with inputs held, outputs checked before any edge
  task automatic apply_reset();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clock);
    check("drain_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  // monitor: outputs are registered, so every cycle presents one response
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("axis_block_sigs", 64'(axis_block_sigs), 64'(e[2:0]));
        check("block_any", 64'(block_any), 64'(e[3]));
        check("first_block_cycle", 64'(first_block_cycle), 64'(e[35:4]));
        check("first_block_ch", 64'(first_block_ch), 64'(e[37:36]));
        check("trace_valid", 64'(trace_valid), 64'(e[38]));
      end
    end
  end

  // stimulus
  initial begin
    logic [N-1:0] v, r;
    logic         idl, clr;
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    check_all_zero("reset_state");
    reset_n = 1'b1;

    // ch0 input stream starved from cycle 0: blocked from cycle 4
    drive_n(6, 3'b000, 3'b001, 1'b0);
    drive_n(2, 3'b000, 3'b000, 1'b0);
    // ch1 output stream stalls 3 cycles, then a transfer: never blocks
    drive_n(3, 3'b010, 3'b000, 1'b0);
    drive_n(1, 3'b010, 3'b010, 1'b0);
    drive_n(2, 3'b000, 3'b000, 1'b0);
    // ch2 blocked, inst_idle for 2 cycles, stall persists and re-blocks
    drive_n(10, 3'b000, 3'b100, 1'b0);
    drive_n(2, 3'b000, 3'b100, 1'b1);
    drive_n(6, 3'b000, 3'b100, 1'b0);
    drive_n(2, 3'b000, 3'b000, 1'b0);
    // clear trace, then ch1 and ch2 block in the same cycle
    drive(3'b000, 3'b000, 1'b0, 1'b1);
    drive_n(6, 3'b010, 3'b100, 1'b0);
    drive(3'b010, 3'b100, 1'b0, 1'b1);
    drive_n(2, 3'b000, 3'b000, 1'b0);
    // ch0 blocked and ch1 mid-count at 3 when reset hits; stall held across reset
    drive_n(3, 3'b000, 3'b001, 1'b0);
    drive_n(3, 3'b010, 3'b001, 1'b0);
    apply_reset();
    drive_n(6, 3'b010, 3'b001, 1'b0);

    // randomized phase with occasional resets
    v = '0;
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          v[i] = 1'($urandom_range(0, 1));
          r[i] = 1'($urandom_range(0, 1));
        end
      end
      idl = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 19) == 0);
      drive(v, r, idl, clr);
      if (c % 500 == 499) apply_reset();
    end

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clock);
    check("final_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
